systolic_array_param: RTL
=========================

Name: systolic_array_param

Overview:
- Parametrised N x N output-stationary systolic array computing C[i][j] = sum_k (A[i][k] + input_offset) * B[k][j] + bias[i] over a runtime-programmable depth K.
- Owns operand skewing, a per-beat valid token for bubble-tolerant loading, pipeline flush, and a row-by-row result drain with ready/valid backpressure.
- Sits between the operand buffers and the requantisation/store stage; replaces the fixed 4x4 array, its external skew delays and its continuous combinational outputs.

Parameters:
- N, 4, array dimension (rows = columns = lanes); N >= 2.
- DW, 8, signed operand width.
- ACC_W, 32, signed accumulator and result width.
- BIAS_W, 14, signed per-row bias width.
- OFF_W, 9, signed input offset width.
- K_W, 16, width of the depth counter k_len.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a tile; sampled only in IDLE.
- k_len  in  K_W  beats in this tile, captured on start.
- input_offset  in  OFF_W  signed, added to every A operand; captured on start.
- bias_in  in  N*BIAS_W  signed per-row bias, row 0 in the MSBs; captured on start.
- in_valid  in  1  a_in/b_in beat valid.
- in_ready  out  1  high in LOAD only.
- a_in  in  N*DW  A column k, lane i feeds row i; lane 0 in the MSBs.
- b_in  in  N*DW  B row k, lane j feeds column j; lane 0 in the MSBs.
- out_valid  out  1  out_row holds a result row.
- out_ready  in  1  consumer accepts out_row.
- out_row  out  N*ACC_W  {C[r][0] .. C[r][N-1]}, column 0 in the MSBs.
- out_row_idx  out  clog2(N)  row index r of out_row.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on acceptance of the last row.

Behaviour:
- Reset values: all outputs 0. State IDLE. Accumulators, skew registers, valid tokens and counters are cleared.
- States: IDLE, LOAD, FLUSH, DRAIN.
- IDLE to LOAD on start when k_len > 0. IDLE to DRAIN on start when k_len = 0; every result is then bias only. start is ignored in all other states.
- On start, all accumulators clear to 0 and the skew pipeline is emptied in the same edge.
- LOAD:
  - A beat is accepted when in_valid & in_ready.
  - Lane i of a_in and b_in is delayed i cycles by the internal skew, together with a 1-bit valid token.
  - Cycles with no accepted beat inject token = 0.
  - After k_len accepted beats, go to FLUSH.
- FLUSH: lasts exactly 2N-1 cycles (counter), long enough for the last token to exit PE[N-1][N-1]. Then go to DRAIN.
- PE behaviour:
  - A passes right and B passes down, each with its token, registered with 1-cycle latency.
  - acc <= acc + sext(a + input_offset) * b only when both tokens are 1.
  - a + input_offset is computed at DW+2 bits signed; the product is full width, sign-extended to ACC_W.
  - Overflow wraps as two's complement, with no saturation.
- DRAIN:
  - Row r = 0..N-1 is presented registered, with out_row_idx = r.
  - Each result is acc[r][j] + sext(bias[r]), wrapped to ACC_W.
  - out_row and out_row_idx hold stable while out_valid & !out_ready.
  - A row advances on out_valid & out_ready.
  - After row N-1 is accepted: done pulses and the state returns to IDLE. A start in that same cycle is ignored.
- Throughput: one beat per cycle in LOAD; one row per cycle in DRAIN when out_ready is held high.
- Latency, from the last accepted beat with no bubbles: FLUSH 2N-1 cycles, then the first out_valid on the next cycle.
- Reset asserted mid-operation: everything returns to reset values immediately. No partial output and no done pulse.

Decomposition:
- Package systolic_pkg holds:
  - the state enum (IDLE, LOAD, FLUSH, DRAIN);
  - the flush-length function (2N-1);
  - the lane-slice helper functions for MSB-first packing.
- Sub-module systolic_pe: one PE carrying the token, the operand pass-through registers and the gated MAC.
- Skew shift registers, FSM and drain mux live in the top level.

Test Plan:
1. N=4, K=4, offset=0, bias=0, A=identity, B rows {1,2,3,4} x row index -> out_row r equals B row r. Rows appear in order 0..3 with done after row 3.
2. K=1, A all 127, B all -128, offset=0, bias=-8192 -> every element = -16256 - 8192 = -24448.
3. K=3 with in_valid low every other cycle, A all 2, B all 3, offset=1 -> all elements 27; the result matches the no-bubble run.
4. K=0 start, bias = {5, -1, 0, 8191} -> the rows are constant vectors 5, -1, 0 and 8191; FLUSH is skipped.
5. out_ready held low 5 cycles on row 2 -> out_row and out_row_idx=2 stay stable; no row is lost or duplicated; done occurs once.
6. rst pulsed in FLUSH, then a fresh K=2 tile with A=1, B=1, offset=0, bias=0 -> all elements = 2, with no residue from the aborted tile.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the parametrised output-stationary systolic array.
// Packed buses are MSB-first: lane 0 occupies the top slice.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Cycles for the last token to travel from PE[0][0] to PE[N-1][N-1] and land.
  function automatic int flush_len(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int lane_lsb(input int lane, input int lanes, input int width);
    return (lanes - 1 - lane) * width;
  endfunction

  function automatic int lane_msb(input int lane, input int lanes, input int width);
    return (lanes - lane) * width - 1;
  endfunction

endpackage

// File: rtl/systolic_array_param_if.sv
// Tile control, operand stream and result stream of the systolic array.
// The slave side is the array itself; the master side is the surrounding datapath.
interface systolic_array_param_if #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int ACC_W  = 32,
  parameter int BIAS_W = 14,
  parameter int OFF_W  = 9,
  parameter int K_W    = 16
);
  localparam int RW = $clog2(N);

  logic                  start;
  logic [K_W-1:0]        k_len;
  logic [OFF_W-1:0]      input_offset;
  logic [N*BIAS_W-1:0]   bias_in;
  logic                  in_valid;
  logic                  in_ready;
  logic [N*DW-1:0]       a_in;
  logic [N*DW-1:0]       b_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [N*ACC_W-1:0]    out_row;
  logic [RW-1:0]         out_row_idx;
  logic                  busy;
  logic                  done;

  modport master (
    output start, k_len, input_offset, bias_in, in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx, busy, done
  );

  modport slave (
    input  start, k_len, input_offset, bias_in, in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, out_row, out_row_idx, busy, done
  );

endinterface

// File: rtl/systolic_pe.sv
// One processing element: registered A/B pass-through with tokens and a token-gated MAC.
module systolic_pe #(
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int OFF_W = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic signed [OFF_W-1:0] offset,
  input  logic [DW-1:0]           a_in,
  input  logic                    a_vld,
  input  logic [DW-1:0]           b_in,
  input  logic                    b_vld,
  output logic [DW-1:0]           a_out,
  output logic                    a_vld_out,
  output logic [DW-1:0]           b_out,
  output logic                    b_vld_out,
  output logic signed [ACC_W-1:0] acc
);
  localparam int AW = DW + 2;
  localparam int PW = AW + DW;

  logic signed [AW-1:0]    a_off_s;
  logic signed [PW-1:0]    a_ext_s;
  logic signed [PW-1:0]    b_ext_s;
  logic signed [PW-1:0]    prod_s;
  logic [DW-1:0]           a_r;
  logic [DW-1:0]           b_r;
  logic                    a_vld_r;
  logic                    b_vld_r;
  logic signed [ACC_W-1:0] acc_r;

  // Offset-adjusted operand and full-width product; the product always fits PW bits.
  always_comb begin
    a_off_s = {{2{a_in[DW-1]}}, a_in} + {{(AW-OFF_W){offset[OFF_W-1]}}, offset};
    a_ext_s = {{DW{a_off_s[AW-1]}}, a_off_s};
    b_ext_s = {{AW{b_in[DW-1]}}, b_in};
    prod_s  = a_ext_s * b_ext_s;
  end

  // Operand pass-through and wrapping accumulate when both tokens line up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      a_vld_r <= 1'b0;
      b_vld_r <= 1'b0;
      acc_r   <= '0;
    end else if (clr) begin
      a_r     <= '0;
      b_r     <= '0;
      a_vld_r <= 1'b0;
      b_vld_r <= 1'b0;
      acc_r   <= '0;
    end else begin
      a_r     <= a_in;
      b_r     <= b_in;
      a_vld_r <= a_vld;
      b_vld_r <= b_vld;
      if (a_vld && b_vld) begin
        acc_r <= acc_r + {{(ACC_W-PW){prod_s[PW-1]}}, prod_s};
      end
    end
  end

  assign a_out     = a_r;
  assign b_out     = b_r;
  assign a_vld_out = a_vld_r;
  assign b_vld_out = b_vld_r;
  assign acc       = acc_r;

endmodule

// File: rtl/systolic_array_param.sv
// N x N output-stationary systolic array with internal operand skew, flush and
// a backpressured row-by-row drain of C = (A + offset) * B + bias.
module systolic_array_param
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int ACC_W  = 32,
  parameter int BIAS_W = 14,
  parameter int OFF_W  = 9,
  parameter int K_W    = 16
) (
  input logic                   clk,
  input logic                   rst,
  systolic_array_param_if.slave bus
);
  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2 * N) + 1;
  localparam logic [FW-1:0]  FLUSH_LAST = FW'(flush_len(N) - 1);
  localparam logic [FW-1:0]  FLUSH_ONE  = FW'(1);
  localparam logic [RW-1:0]  ROW_LAST   = RW'(N - 1);
  localparam logic [RW-1:0]  ROW_ONE    = RW'(1);
  localparam logic [K_W-1:0] K_ONE      = K_W'(1);

  state_e                  state_r;
  state_e                  state_s;
  logic                    accept_s;
  logic                    clear_s;
  logic                    load_row_s;
  logic                    zero_k_s;
  logic                    last_row_s;
  logic [RW-1:0]           row_sel_s;
  logic [K_W-1:0]          k_len_r;
  logic [K_W-1:0]          beat_cnt_r;
  logic [FW-1:0]           flush_cnt_r;
  logic signed [OFF_W-1:0] offset_r;
  logic [N*BIAS_W-1:0]     bias_r;
  logic                    in_ready_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    out_valid_r;
  logic [N*ACC_W-1:0]      out_row_r;
  logic [RW-1:0]           row_idx_r;
  logic [N*ACC_W-1:0]      row_val_s;
  logic signed [BIAS_W-1:0] bias_sel_s;
  logic signed [ACC_W-1:0]  bias_ext_s;
  logic                    edge_unused_s;

  logic [DW-1:0]           a_sk_s   [N];
  logic [DW-1:0]           b_sk_s   [N];
  logic                    tok_sk_s [N];
  logic [DW-1:0]           a_h_s    [N][N];
  logic                    av_h_s   [N][N];
  logic [DW-1:0]           b_v_s    [N][N];
  logic                    bv_v_s   [N][N];
  logic [DW-1:0]           a_o_s    [N][N];
  logic                    ao_v_s   [N][N];
  logic [DW-1:0]           b_o_s    [N][N];
  logic                    bo_v_s   [N][N];
  logic signed [ACC_W-1:0] acc_s    [N][N];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    clear_s    = 1'b0;
    load_row_s = 1'b0;
    zero_k_s   = 1'b0;
    last_row_s = 1'b0;
    row_sel_s  = '0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          clear_s = 1'b1;
          if (bus.k_len == '0) begin
            state_s    = DRAIN;
            load_row_s = 1'b1;
            zero_k_s   = 1'b1;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        accept_s = bus.in_valid & in_ready_r;
        if (accept_s && (beat_cnt_r == k_len_r - K_ONE)) begin
          state_s = FLUSH;
        end else begin
          state_s = LOAD;
        end
      end
      FLUSH: begin
        if (flush_cnt_r == FLUSH_LAST) begin
          state_s    = DRAIN;
          load_row_s = 1'b1;
        end else begin
          state_s = FLUSH;
        end
      end
      DRAIN: begin
        row_sel_s = row_idx_r + ROW_ONE;
        if (out_valid_r && bus.out_ready) begin
          if (row_idx_r == ROW_LAST) begin
            state_s    = IDLE;
            last_row_s = 1'b1;
          end else begin
            state_s    = DRAIN;
            load_row_s = 1'b1;
          end
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Tile parameters captured on start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_len_r  <= '0;
      offset_r <= '0;
      bias_r   <= '0;
    end else if (clear_s) begin
      k_len_r  <= bus.k_len;
      offset_r <= bus.input_offset;
      bias_r   <= bus.bias_in;
    end
  end

  // Accepted-beat and flush-length counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_r  <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (clear_s) begin
        beat_cnt_r <= '0;
      end else if (accept_s) begin
        beat_cnt_r <= beat_cnt_r + K_ONE;
      end
      flush_cnt_r <= (state_r == FLUSH) ? flush_cnt_r + FLUSH_ONE : '0;
    end
  end

  // Lane i is delayed i cycles so operand k meets PE[i][j] at cycle k+i+j.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] a_lane_s;
    logic [DW-1:0] b_lane_s;
    assign a_lane_s = accept_s ? bus.a_in[lane_lsb(i, N, DW) +: DW] : '0;
    assign b_lane_s = accept_s ? bus.b_in[lane_lsb(i, N, DW) +: DW] : '0;
    if (i == 0) begin : g_direct
      assign a_sk_s[i]   = a_lane_s;
      assign b_sk_s[i]   = b_lane_s;
      assign tok_sk_s[i] = accept_s;
    end else begin : g_delay
      logic [DW-1:0] a_d_r [i];
      logic [DW-1:0] b_d_r [i];
      logic          t_d_r [i];
      // Skew shift register for this lane
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d < i; d++) begin
            a_d_r[d] <= '0;
            b_d_r[d] <= '0;
            t_d_r[d] <= 1'b0;
          end
        end else if (clear_s) begin
          for (int d = 0; d < i; d++) begin
            a_d_r[d] <= '0;
            b_d_r[d] <= '0;
            t_d_r[d] <= 1'b0;
          end
        end else begin
          a_d_r[0] <= a_lane_s;
          b_d_r[0] <= b_lane_s;
          t_d_r[0] <= accept_s;
          for (int d = 1; d < i; d++) begin
            a_d_r[d] <= a_d_r[d-1];
            b_d_r[d] <= b_d_r[d-1];
            t_d_r[d] <= t_d_r[d-1];
          end
        end
      end
      assign a_sk_s[i]   = a_d_r[i-1];
      assign b_sk_s[i]   = b_d_r[i-1];
      assign tok_sk_s[i] = t_d_r[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_h_s[i][j]  = a_sk_s[i];
        assign av_h_s[i][j] = tok_sk_s[i];
      end else begin : g_a_link
        assign a_h_s[i][j]  = a_o_s[i][j-1];
        assign av_h_s[i][j] = ao_v_s[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_v_s[i][j]  = b_sk_s[j];
        assign bv_v_s[i][j] = tok_sk_s[j];
      end else begin : g_b_link
        assign b_v_s[i][j]  = b_o_s[i-1][j];
        assign bv_v_s[i][j] = bo_v_s[i-1][j];
      end
      systolic_pe #(
        .DW    (DW),
        .ACC_W (ACC_W),
        .OFF_W (OFF_W)
      ) u_pe (
        .clk       (clk),
        .rst       (rst),
        .clr       (clear_s),
        .offset    (offset_r),
        .a_in      (a_h_s[i][j]),
        .a_vld     (av_h_s[i][j]),
        .b_in      (b_v_s[i][j]),
        .b_vld     (bv_v_s[i][j]),
        .a_out     (a_o_s[i][j]),
        .a_vld_out (ao_v_s[i][j]),
        .b_out     (b_o_s[i][j]),
        .b_vld_out (bo_v_s[i][j]),
        .acc       (acc_s[i][j])
      );
    end
  end

  // Operands leaving the right and bottom edges have no consumer.
  always_comb begin
    edge_unused_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      edge_unused_s = edge_unused_s ^ (^a_o_s[i][N-1]) ^ ao_v_s[i][N-1]
                    ^ (^b_o_s[N-1][i]) ^ bo_v_s[N-1][i];
    end
  end

  // Drain mux: next row plus its bias; a zero-depth tile uses the bias being captured now.
  always_comb begin
    row_val_s  = '0;
    bias_sel_s = zero_k_s ? bus.bias_in[lane_lsb(int'(row_sel_s), N, BIAS_W) +: BIAS_W]
                          : bias_r[lane_lsb(int'(row_sel_s), N, BIAS_W) +: BIAS_W];
    bias_ext_s = {{(ACC_W-BIAS_W){bias_sel_s[BIAS_W-1]}}, bias_sel_s};
    for (int j = 0; j < N; j++) begin
      if (zero_k_s) begin
        row_val_s[lane_lsb(j, N, ACC_W) +: ACC_W] = bias_ext_s;
      end else begin
        row_val_s[lane_lsb(j, N, ACC_W) +: ACC_W] = acc_s[row_sel_s][j] + bias_ext_s;
      end
    end
  end

  // Registered status and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_row_r   <= '0;
      row_idx_r   <= '0;
    end else begin
      in_ready_r <= (state_s == LOAD);
      busy_r     <= (state_s != IDLE);
      done_r     <= last_row_s;
      if (load_row_s) begin
        out_valid_r <= 1'b1;
        out_row_r   <= row_val_s;
        row_idx_r   <= row_sel_s;
      end else if (last_row_s) begin
        out_valid_r <= 1'b0;
        out_row_r   <= '0;
        row_idx_r   <= '0;
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_row     = out_row_r;
  assign bus.out_row_idx = row_idx_r;

endmodule
